// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the iterative multiply/divide sequencer.
//   mdu_op_e      : operation code as driven on mdu_seq.op
//   mdu_state_e   : sequencer states (IDLE -> RUN -> FIX -> IDLE)
//   mdu_cnt_width : iteration-counter width for a given operand width
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  // Counter must be able to hold 0..width.
  function automatic int mdu_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_width(MDU_WIDTH);

  function automatic logic mdu_is_mul(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational two's-complement conditioner for a pair of WIDTH-bit words.
//   joined = 0 : in_hi and in_lo are independent words; each is negated when
//                its own neg_* flag is set (operand magnitudes, quotient and
//                remainder fix-up).
//   joined = 1 : {in_hi, in_lo} is one 2*WIDTH value, negated as a whole when
//                neg_lo is set (product fix-up); neg_hi is ignored.
// Ports:
//   in_hi, in_lo   : input words
//   neg_hi, neg_lo : negate requests
//   joined         : treat the pair as a single double-width value
//   out_hi, out_lo : conditioned words
// -----------------------------------------------------------------------------
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joined,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic lo_zero;
  logic hi_neg;
  logic hi_inc;

  always_comb begin
    lo_zero = (in_lo == '0);
    // A double-width negate is ~{hi,lo}+1: the +1 only ripples into the
    // upper word when the lower word is zero.
    hi_neg  = joined ? neg_lo : neg_hi;
    hi_inc  = joined ? lo_zero : 1'b1;
    out_lo  = neg_lo ? (~in_lo + WIDTH'(1)) : in_lo;
    out_hi  = hi_neg ? (~in_hi + WIDTH'(hi_inc)) : in_hi;
  end

endmodule

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
// Iterative multiply/divide sequencer owning the HI/LO registers.
// MULT/MULTU use shift-add on operand magnitudes, DIV/DIVU use restoring
// division on magnitudes; signs are applied in the FIX state.
//
// Parameters:
//   WIDTH : operand width (even, >= 4); hi/lo are WIDTH bits each
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   start, op, a, b: launch request (sampled only in IDLE), opcode, operands
//   hi_we, lo_we,
//   wdata          : MTHI/MTLO writes, honoured only when not busy
//   busy           : operation in progress (RUN or FIX)
//   done           : one-cycle pulse, hi/lo hold the new result
//   hi, lo         : architectural HI/LO registers
//
// Build option:
//   MDU_EARLY_TERM_EN : multiplies leave RUN once the remaining multiplier
//                       bits are all zero (at least one RUN cycle).
// -----------------------------------------------------------------------------
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mdu_cnt_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CW-1:0]    cnt;

  // Working registers, shared between the two algorithms:
  //   multiply: acc = running product, opa = multiplicand shifted left,
  //             opb = remaining multiplier bits shifted right
  //   divide  : acc = {remainder, quotient/dividend}, opa[WIDTH-1:0] = divisor
  logic [W2-1:0]    acc;
  logic [W2-1:0]    opa;
  logic [WIDTH-1:0] opb;

  logic             is_mul_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             div_zero_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Control strobes from the output decoder.
  logic             launch;
  logic             step;
  logic             fix;
  logic             last_iter;

  // ---------------------------------------------------------------------------
  // Operand decode and magnitude extraction
  // ---------------------------------------------------------------------------
  mdu_op_e          op_e;
  logic             op_mul;
  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_e      = mdu_op_e'(op);
  assign op_mul    = mdu_is_mul(op_e);
  assign op_signed = mdu_is_signed(op_e);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .in_hi  (a),
    .in_lo  (b),
    .neg_hi (op_signed & a[WIDTH-1]),
    .neg_lo (op_signed & b[WIDTH-1]),
    .joined (1'b0),
    .out_hi (a_mag),
    .out_lo (b_mag)
  );

  // ---------------------------------------------------------------------------
  // Result sign fix-up (used in FIX)
  // ---------------------------------------------------------------------------
  logic             res_neg_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Divide by zero keeps the all-ones quotient regardless of signs; the
  // remainder path still restores the dividend's sign so hi ends up equal to a.
  assign res_neg_lo = (neg_a_q ^ neg_b_q) & (is_mul_q | ~div_zero_q);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .in_hi  (acc[W2-1:WIDTH]),
    .in_lo  (acc[WIDTH-1:0]),
    .neg_hi (neg_a_q),
    .neg_lo (res_neg_lo),
    .joined (is_mul_q),
    .out_hi (res_hi),
    .out_lo (res_lo)
  );

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [W2-1:0]    mul_acc_nxt;
  logic [W2-1:0]    div_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  always_comb begin
    mul_acc_nxt = opb[0] ? (acc + opa) : acc;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // The remainder stays below the divisor, so WIDTH+1 bits suffice and bit
    // WIDTH of the difference is the borrow.
    div_shift   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opa[WIDTH-1:0]};
    div_ge      = ~div_diff[WIDTH];
    div_acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};
  end

`ifdef MDU_EARLY_TERM_EN
  // Multiplies stop once no set multiplier bits remain after this iteration.
  assign last_iter = (cnt == CW'(WIDTH - 1)) |
                     (is_mul_q & (opb[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of the block keeps every path
  // assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state != S_IDLE);
    launch = (state == S_IDLE) & start;
    step   = (state == S_RUN);
    fix    = (state == S_FIX);
  end

  // ---------------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here, working ones included, is reset so an aborted
  // operation leaves nothing behind; there is no memory array to exempt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      is_mul_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= fix;

      if (launch) begin
        cnt        <= '0;
        is_mul_q   <= op_mul;
        neg_a_q    <= op_signed & a[WIDTH-1];
        neg_b_q    <= op_signed & b[WIDTH-1];
        div_zero_q <= (b == '0);
        acc        <= op_mul ? '0 : {{WIDTH{1'b0}}, a_mag};
        opa        <= {{WIDTH{1'b0}}, (op_mul ? a_mag : b_mag)};
        opb        <= b_mag;
      end else if (step) begin
        cnt <= cnt + CW'(1);
        opb <= opb >> 1;
        if (is_mul_q) begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
        end else begin
          acc <= div_acc_nxt;
        end
      end

      // MTHI/MTLO only while idle; a launch in the same cycle still writes,
      // and the operation overwrites both registers when it completes.
      if (fix) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state == S_IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq
// Self-checking bench for mdu_seq (WIDTH = 32). A behavioural model computes
// results with plain 64-bit arithmetic and tracks latency as a cycle budget;
// one compare process checks busy/done/hi/lo every cycle against it, and
// directed vectors pin the model with hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Returns {hi, lo} for an operation.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Number of RUN cycles for an operation.
  function automatic int ref_iters(input logic [1:0] o, input logic [31:0] y);
    int k;
    k = W;
`ifdef MDU_EARLY_TERM_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = (o == 2'b00 && y[31]) ? (32'd0 - y) : y;
      k = 1;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    end
`endif
    return k;
  endfunction

  int          m_left;  // busy cycles still to come; 0 = idle
  logic        m_done;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_rhi  <= '0;
      m_rlo  <= '0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (hi_we) m_hi <= wdata;
      if (lo_we) m_lo <= wdata;
      if (start) begin
        m_left         <= ref_iters(op, b) + 1;
        {m_rhi, m_rlo} <= ref_result(op, a, b);
      end
    end else begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_rhi;
        m_lo <= m_rlo;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_left != 0);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Launches one operation and waits (bounded) for done. Operands are scrambled
  // while busy; disturb_at injects an ignored start/MTHI at that busy cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit have_exp, input logic [31:0] ehi,
                        input logic [31:0] elo, input int disturb_at, input bit immediate,
                        input logic [1:0] wr);
    int n;
    int busy_n;
    int lat;
    bit seen;
    if (!immediate) @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    hi_we = wr[1];
    lo_we = wr[0];
    wdata = $urandom;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else if (n == disturb_at) begin
        start = 1'b1;
        op    = 2'b10;
        hi_we = 1'b1;
        wdata = 32'hDEAD;
      end
    end
    lat = ref_iters(o, y) + 2;
    check({name, " latency"}, n, lat);
    check({name, " busy cycles"}, busy_n, lat - 1);
    if (have_exp) begin
      check({name, " hi"}, hi, ehi);
      check({name, " lo"}, lo, elo);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 2'b00);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 2'b00);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0, 0, 2'b00);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 2'b00);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 0, 0, 2'b00);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 0, 0, 2'b00);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 2'b00);

    // MTHI in IDLE.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h1234);

    // Ignored start/MTHI while busy, then back-to-back launch in the done cycle.
    run_op("multu_disturbed", 2'b01, 32'd2, 32'd3, 1, 32'd0, 32'd6, 5, 0, 2'b00);
    run_op("b2b_divu", 2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 1, 2'b00);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd9;
    b     = 32'd9;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst hi", hi, 0);
    check("midrst lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu_after_rst", 2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 0, 2'b00);

    // Early-termination vectors (full latency when the option is off).
    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 1, 32'd0, 32'd15, 0, 0, 2'b00);
    run_op("multu_5x0", 2'b01, 32'd5, 32'd0, 1, 32'd0, 32'd0, 0, 0, 2'b00);
    run_op("mult_neg_b", 2'b00, 32'd5, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 0, 0, 2'b00);

    // Launch with simultaneous MTHI/MTLO: writes land, then the result wins.
    run_op("start_with_mt", 2'b01, 32'd4, 32'd4, 1, 32'd0, 32'd16, 0, 0, 2'b11);

    // Randomized operations, MT writes and disturbances.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        hi_we = 1'($urandom);
        lo_we = 1'($urandom);
        wdata = $urandom;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      run_op("rand", 2'($urandom), pick_operand(), pick_operand(), 0, '0, '0,
             $urandom_range(0, 40), 1'($urandom), 2'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
